// File: rtl/baud_frame_timer.sv
// Programmable bit-period / frame timer: mid-bit and end-of-bit strobes, bit index, frame completion.
// Latency: strobes are registered; first bit_tick (div_q or (div_q>>1))+1 cycles after start acceptance.
// Backpressure: en_i low freezes the count in RUN; start_i is only honoured in IDLE.
module baud_frame_timer #(
    parameter int DIV_W    = 16,
    parameter int MAX_BITS = 12,
    parameter int BIT_W    = $clog2(MAX_BITS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             soft_rst_i,
    input  logic             start_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [BIT_W-1:0] nbits_i,
    input  logic             half_first_i,
    output logic             busy_o,
    output logic             mid_tick_o,
    output logic             bit_tick_o,
    output logic             frame_done_o,
    output logic [BIT_W-1:0] bit_idx_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [BIT_W-1:0] NBITS_MIN = BIT_W'(1);
    localparam logic [BIT_W-1:0] NBITS_MAX = BIT_W'(MAX_BITS);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] nbits_q, nbits_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic             busy_q, busy_d;
    logic             mid_q, mid_d;
    logic             bit_q, bit_d;
    logic             done_q, done_d;

    // Clamped copies of the start-time parameters; only consumed on acceptance.
    logic [DIV_W-1:0] div_sel;
    logic [BIT_W-1:0] nbits_sel;

    // Next-state, counter and strobe generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        nbits_d   = nbits_q;
        bit_idx_d = bit_idx_q;
        mid_d     = 1'b0;
        bit_d     = 1'b0;
        done_d    = 1'b0;

        div_sel = (div_i < DIV_MIN) ? DIV_MIN : div_i;
        if (nbits_i == '0) begin
            nbits_sel = NBITS_MIN;
        end else if (nbits_i > NBITS_MAX) begin
            nbits_sel = NBITS_MAX;
        end else begin
            nbits_sel = nbits_i;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    div_d     = div_sel;
                    nbits_d   = nbits_sel;
                    // Half-length first period centres the RX sampler on the start bit.
                    cnt_d     = half_first_i ? ((div_sel >> 1) - DIV_ONE) : (div_sel - DIV_ONE);
                    bit_idx_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (en_i) begin
                    if (cnt_q == '0) begin
                        bit_d     = 1'b1;
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        cnt_d     = div_q - DIV_ONE;
                        if (bit_idx_q == nbits_q - BIT_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - DIV_ONE;
                    end
                    // div_q>>1 is at least 1, so this never coincides with the terminal count.
                    if (cnt_q == (div_q >> 1)) begin
                        mid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    // State and output registers with synchronous hard and soft reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i || soft_rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_MIN;
            nbits_q   <= NBITS_MIN;
            bit_idx_q <= '0;
            busy_q    <= 1'b0;
            mid_q     <= 1'b0;
            bit_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            nbits_q   <= nbits_d;
            bit_idx_q <= bit_idx_d;
            busy_q    <= busy_d;
            mid_q     <= mid_d;
            bit_q     <= bit_d;
            done_q    <= done_d;
        end
    end

    assign busy_o       = busy_q;
    assign mid_tick_o   = mid_q;
    assign bit_tick_o   = bit_q;
    assign frame_done_o = done_q;
    assign bit_idx_o    = bit_idx_q;

endmodule

// File: tb/tb_baud_frame_timer.sv
// Bench for baud_frame_timer: frame table, abort sequences and randomized traffic.
// Every cycle is compared against an elapsed-enabled-cycle reference model.
// Inputs are driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_baud_frame_timer;

    localparam int DIV_W    = 16;
    localparam int MAX_BITS = 12;
    localparam int BIT_W    = $clog2(MAX_BITS + 1);

    logic             clk_i;
    logic             rst_i;
    logic             soft_rst_i;
    logic             start_i;
    logic             en_i;
    logic [DIV_W-1:0] div_i;
    logic [BIT_W-1:0] nbits_i;
    logic             half_first_i;
    logic             busy_o;
    logic             mid_tick_o;
    logic             bit_tick_o;
    logic             frame_done_o;
    logic [BIT_W-1:0] bit_idx_o;

    baud_frame_timer #(
        .DIV_W   (DIV_W),
        .MAX_BITS(MAX_BITS),
        .BIT_W   (BIT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .soft_rst_i  (soft_rst_i),
        .start_i     (start_i),
        .en_i        (en_i),
        .div_i       (div_i),
        .nbits_i     (nbits_i),
        .half_first_i(half_first_i),
        .busy_o      (busy_o),
        .mid_tick_o  (mid_tick_o),
        .bit_tick_o  (bit_tick_o),
        .frame_done_o(frame_done_o),
        .bit_idx_o   (bit_idx_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference model: a frame is a run of enabled cycles; bit ends and mid points
    // fall at fixed arithmetic offsets from the acceptance, measured in enabled cycles.
    bit m_run  = 1'b0;
    bit m_half = 1'b0;
    int m_e    = 0;
    int m_D    = 2;
    int m_N    = 1;
    int m_idx  = 0;
    bit x_busy = 1'b0, x_mid = 1'b0, x_bit = 1'b0, x_done = 1'b0;

    task automatic model_edge();
        int r;
        x_mid  = 1'b0;
        x_bit  = 1'b0;
        x_done = 1'b0;
        if (!rst_i || soft_rst_i) begin
            m_run = 1'b0;
            m_idx = 0;
        end else if (!m_run) begin
            if (start_i) begin
                m_D    = (int'(div_i) < 2) ? 2 : int'(div_i);
                m_N    = (nbits_i == 0) ? 1 : ((int'(nbits_i) > MAX_BITS) ? MAX_BITS : int'(nbits_i));
                m_half = half_first_i;
                m_e    = 0;
                m_idx  = 0;
                m_run  = 1'b1;
            end
        end else if (en_i) begin
            m_e++;
            r = m_e - (m_half ? m_D / 2 : 0);
            if (r >= 0 && (r % m_D) == 0) begin
                x_bit = 1'b1;
                m_idx = r / m_D + (m_half ? 1 : 0);
                if (m_idx == m_N) begin
                    x_done = 1'b1;
                    m_run  = 1'b0;
                end
            end
            if (r > 0 && (r % m_D) == m_D - m_D / 2) x_mid = 1'b1;
        end
        x_busy = m_run;
    endtask

    task automatic set_in(input bit r, input bit s, input bit st, input bit e,
                          input int dv, input int nb, input bit hf);
        rst_i        = r;
        soft_rst_i   = s;
        start_i      = st;
        en_i         = e;
        div_i        = DIV_W'(dv);
        nbits_i      = BIT_W'(nb);
        half_first_i = hf;
    endtask

    // One clock with the current inputs; compares all outputs with the model.
    task automatic step();
        logic [4+BIT_W-1:0] act, exp;
        model_edge();
        @(posedge clk_i);
        #1;
        act = {busy_o, mid_tick_o, bit_tick_o, frame_done_o, bit_idx_o};
        exp = {x_busy, x_mid, x_bit, x_done, BIT_W'(m_idx)};
        check("cycle_outputs{busy,mid,bit,done,idx}", int'(act), int'(exp));
    endtask

    // Accepts a frame on the first clock, then runs until frame_done or a cycle budget.
    // Cycle n is the value seen after the n-th edge counted from the acceptance edge.
    task automatic run_frame(input int dv, input int nb, input int hf,
                             input int lo, input int hi, input int sa,
                             output int fm, output int fb, output int dc,
                             output int cm, output int cb, output int fi);
        int  cyc;
        int  c;
        bit  seen;
        fm = -1; fb = -1; dc = -1; cm = 0; cb = 0; fi = -1;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 400) begin
            if (cyc == 1) begin
                set_in(1'b1, 1'b0, 1'b1, 1'b1, dv, nb, hf != 0);
            end else begin
                c = cyc - 1;
                // Parameters wander while running; they must be ignored.
                set_in(1'b1, 1'b0, c == sa, !(c >= lo && c <= hi),
                       int'($urandom_range(0, 65535)), int'($urandom_range(0, 15)),
                       $urandom_range(0, 1) == 1);
            end
            step();
            if (cyc == 1) check("busy_after_accept", int'(busy_o), 1);
            if (mid_tick_o) begin
                cm++;
                if (fm < 0) fm = cyc;
            end
            if (bit_tick_o) begin
                cb++;
                if (fb < 0) fb = cyc;
            end
            if (frame_done_o) begin
                dc   = cyc;
                fi   = int'(bit_idx_o);
                seen = 1'b1;
                check("busy_low_at_done", int'(busy_o), 0);
            end
            cyc++;
        end
        if (!seen) check("frame_done_timeout", 0, 1);
    endtask

    typedef struct {
        int dv, nb, hf, lo, hi, sa;
        int fm, fb, dc, cm, cb, fi;
    } vec_t;

    vec_t tbl[10];

    task automatic check_frame(input string tag, input vec_t v);
        int fm, fb, dc, cm, cb, fi;
        run_frame(v.dv, v.nb, v.hf, v.lo, v.hi, v.sa, fm, fb, dc, cm, cb, fi);
        check({tag, "_first_mid"}, fm, v.fm);
        check({tag, "_first_bit"}, fb, v.fb);
        check({tag, "_done_cycle"}, dc, v.dc);
        check({tag, "_mid_count"}, cm, v.cm);
        check({tag, "_bit_count"}, cb, v.cb);
        check({tag, "_final_idx"}, fi, v.fi);
    endtask

    // Starts a div=4 three-bit frame, aborts it just before the second bit end,
    // then checks that a later frame is unaffected.
    task automatic abort_test(input string tag, input bit use_soft);
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 4, 3, 1'b0);
        step();
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b1, 4, 3, 1'b0);
            step();
        end
        check({tag, "_pre_abort_idx"}, int'(bit_idx_o), 1);
        if (use_soft) set_in(1'b1, 1'b1, 1'b1, 1'b1, 4, 3, 1'b0);
        else          set_in(1'b0, 1'b0, 1'b1, 1'b1, 4, 3, 1'b0);
        step();
        check({tag, "_abort_outputs"},
              int'({busy_o, mid_tick_o, bit_tick_o, frame_done_o, bit_idx_o}), 0);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 4, 3, 1'b0);
        step();
        check({tag, "_idle_after_abort"}, int'({busy_o, bit_tick_o}), 0);
        check_frame({tag, "_fresh"}, tbl[0]);
    endtask

    initial begin
        //          dv  nb hf  lo  hi  sa   fm  fb  dc cm  cb  fi
        tbl[0] = '{  4,  3, 0, -1, -1, -1,   3,  5, 13, 3,  3,  3};
        tbl[1] = '{  8,  2, 1, -1, -1, -1,   9,  5, 13, 1,  2,  2};
        tbl[2] = '{  0,  1, 0, -1, -1, -1,   2,  3,  3, 1,  1,  1};
        tbl[3] = '{  5,  0, 0, -1, -1, -1,   4,  6,  6, 1,  1,  1};
        tbl[4] = '{  2, 15, 0, -1, -1, -1,   2,  3, 25, 12, 12, 12};
        tbl[5] = '{  3,  4, 1, -1, -1, -1,   4,  2, 11, 3,  4,  4};
        tbl[6] = '{  1,  2, 1, -1, -1, -1,   3,  2,  4, 1,  2,  2};
        tbl[7] = '{ 16,  1, 1, -1, -1, -1,  -1,  9,  9, 0,  1,  1};
        tbl[8] = '{  4,  3, 0,  2,  3,  6,   5,  7, 15, 3,  3,  3};
        tbl[9] = '{ 12,  2, 0, 12, 12, -1,   7, 14, 26, 2,  2,  2};

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step();
        step();
        check("reset_busy", int'(busy_o), 0);
        check("reset_strobes", int'({mid_tick_o, bit_tick_o, frame_done_o}), 0);
        check("reset_idx", int'(bit_idx_o), 0);

        set_in(1'b1, 1'b0, 1'b0, 1'b1, 4, 3, 1'b0);
        step();

        // Each row starts in the frame_done cycle of the previous one (back-to-back).
        for (int i = 0; i < 10; i++) begin
            check_frame($sformatf("row%0d", i), tbl[i]);
        end

        // bit_idx holds in IDLE after a frame.
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 7, 5, 1'b0);
        step();
        step();
        check("idle_idx_hold", int'(bit_idx_o), 2);
        check("idle_not_busy", int'(busy_o), 0);

        abort_test("hard_rst", 1'b0);
        abort_test("soft_rst", 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            set_in($urandom_range(0, 199) != 0, $urandom_range(0, 149) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                   int'($urandom_range(0, 10)), int'($urandom_range(0, 15)),
                   $urandom_range(0, 1) == 1);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/baud_frame_timer.md
# baud_frame_timer

Programmable bit-period and frame timer for the UART datapath, successor to the fixed-divisor clock counter. It counts a runtime-selected number of clocks per bit and emits a mid-bit sample strobe and an end-of-bit strobe. It also tracks the bit index across a frame of runtime-selected length and signals frame completion. The RX and TX FSMs consume its strobes, and it replaces per-FSM clock counting.

## Interface
- DIV_W, 16: width of the clocks-per-bit divisor.
- MAX_BITS, 12: maximum bits per frame.
- BIT_W, $clog2(MAX_BITS+1): width of the bit count and bit index.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset: one clock; reset is synchronous and active-low.
- soft_rst  in  1  synchronous abort, active-high; same effect as rst.
- start  in  1  frame start request; honoured only in IDLE.
- en  in  1  count enable; low freezes the counter in RUN.
- div  in  DIV_W  clocks per bit; sampled when start is accepted.
- nbits  in  BIT_W  bits per frame; sampled when start is accepted.
- half_first  in  1  first bit period is half length (RX start-bit centring); sampled when start is accepted.
- busy  out  1  high in RUN.
- mid_tick  out  1  one-cycle mid-bit sample strobe.
- bit_tick  out  1  one-cycle end-of-bit strobe.
- frame_done  out  1  one-cycle strobe, coincident with the last bit_tick.
- bit_idx  out  BIT_W  number of bits completed in the current frame.

## Operation
- States: IDLE and RUN. All outputs are registered.
- **Reset:** when rst=0 at a clock edge (or soft_rst=1 with rst=1):
  - state goes to IDLE.
  - busy, mid_tick, bit_tick, frame_done and bit_idx go to 0; the internal cnt goes to 0.
  - rst has priority over soft_rst, and soft_rst has priority over all other inputs.
- **Start accepted** (IDLE and start=1):
  - Latch div_q = max(div, 2).
  - Latch nbits_q = nbits clamped to [1, MAX_BITS].
  - Load cnt = (div_q>>1)-1 if half_first=1, otherwise div_q-1.
  - Clear bit_idx; go to RUN; busy=1 from the next cycle.
- **RUN with en=1:**
  - If cnt==0: next cycle bit_tick=1, bit_idx increments, cnt reloads to div_q-1.
  - Otherwise cnt decrements.
  - If cnt==(div_q>>1): next cycle mid_tick=1.
  - A half-length first period never reaches that value, so it produces no mid_tick.
- **RUN with en=0:** cnt, bit_idx and state hold; no strobes are generated, including when cnt==0.
- **Frame end:** the terminal count of bit nbits_q-1 ends the frame.
  - In the next cycle, bit_tick=1, frame_done=1, bit_idx=nbits_q, busy=0, and state is IDLE.
  - bit_idx holds its value until the next start is accepted.
- **start in RUN:** ignored; the latched div_q, nbits_q and mode are unaffected.
- **Back-to-back frames:** start=1 in the frame_done cycle is accepted, giving a new RUN with no idle gap.
- **Arithmetic:** cnt is DIV_W bits, unsigned, and never wraps below 0 (it reloads at 0). div changing during RUN has no effect.

## Timing
- Example with div=4, half_first=0, en held at 1:
  - start accepted at cycle 0.
  - busy=1 and cnt=3 at cycle 1.
  - mid_tick at cycle 3.
  - bit_tick at cycles 5, 9, 13, …
- Full period: bit_tick spacing is div_q cycles. mid_tick lands ((div_q-1)-(div_q>>1)) enabled cycles after the load, plus one register stage.
- Half-length first period: first bit_tick after (div_q>>1)+1 cycles from acceptance, then every div_q cycles.
- Frame latency: frame_done at cycle (first-period length + 1) + (nbits_q-1)·div_q after acceptance.
- Each en=0 cycle in RUN delays all subsequent strobes by exactly one cycle.

## Test plan
- **Reset:** drive rst=0 mid-frame → next cycle busy=0, bit_idx=0, no strobes; a start 1 cycle later behaves like a fresh frame.
- **Basic frame:** div=4, nbits=3, half_first=0, en=1, start at cycle 0 → mid_tick at 3, 7, 11; bit_tick at 5, 9, 13; frame_done and busy=0 at 13; bit_idx=3.
- **Half first period:** div=8, nbits=2, half_first=1 → first bit_tick at cycle 5 with no mid_tick before it; mid_tick at 9; bit_tick and frame_done at 13.
- **Clamping:** div=0 behaves as div=2; nbits=0 gives one bit; nbits=15 with MAX_BITS=12 → frame_done after 12 bit_ticks.
- **Enable gating and start while busy:** in the div=4 frame, drop en for 2 cycles before the first terminal count → all strobes shift by 2; a start pulse during RUN changes nothing.
- **Back-to-back and abort:** start=1 in the frame_done cycle → new frame begins with busy staying 1 from the following cycle; soft_rst=1 mid-frame → IDLE next cycle with no strobes.
